// File: rtl/rd_xbar_port_scheduler.sv
// rtl/rd_xbar_port_scheduler.sv - credit-based round-robin scheduler for the N-to-4 read request crossbar
module rd_xbar_port_scheduler #(
   parameter int R_REQ_NUM = 8,
   parameter int CRD_MAX   = 4,
   parameter int IDX_W     = $clog2(R_REQ_NUM),
   parameter int CRD_W     = $clog2(CRD_MAX + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [R_REQ_NUM-1:0]             req_vld,
   input  logic [R_REQ_NUM-1:0][1:0]        req_sel,
   output logic [R_REQ_NUM-1:0]             req_rdy,
   input  logic [3:0]                       port_en,
   output logic [3:0]                       gnt_vld,
   output logic [3:0][IDX_W-1:0]            gnt_idx,
   input  logic [3:0]                       gnt_rdy,
   input  logic [3:0]                       crd_rtn,
   output logic [3:0][CRD_W-1:0]            crd_cnt
);

   logic [3:0][R_REQ_NUM-1:0] cand;
   logic [3:0]                win_vld;
   logic [3:0][IDX_W-1:0]     win_idx;
   logic [3:0][IDX_W-1:0]     rr_ptr;
   logic [3:0][IDX_W-1:0]     rr_nxt;
   logic [3:0]                cap;
   logic [3:0][CRD_W-1:0]     crd_q;
   logic [3:0][CRD_W-1:0]     crd_nxt;

   assign crd_cnt = crd_q;

   // Build candidate sets and pick the first requester at or after rr_ptr for each port
   always_comb begin
      int j;
      int nxt;
      logic [CRD_W:0] crd_sum;
      cand    = '0;
      win_vld = '0;
      win_idx = '0;
      rr_nxt  = '0;
      cap     = '0;
      crd_nxt = '0;
      crd_sum = '0;
      j       = 0;
      nxt     = 0;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < R_REQ_NUM; i++) begin
            cand[p][i] = req_vld[i] & (req_sel[i] == 2'(p));
         end
         for (int k = 0; k < R_REQ_NUM; k++) begin
            j = int'(rr_ptr[p]) + k;
            if (j >= R_REQ_NUM) begin
               j = j - R_REQ_NUM;
            end
            if (!win_vld[p] && cand[p][j]) begin
               win_vld[p] = 1'b1;
               win_idx[p] = IDX_W'(j);
            end
         end
         nxt = int'(win_idx[p]) + 1;
         if (nxt >= R_REQ_NUM) begin
            nxt = 0;
         end
         rr_nxt[p] = IDX_W'(nxt);
         cap[p] = port_en[p] & (crd_q[p] != '0) & win_vld[p] & (~gnt_vld[p] | gnt_rdy[p]);
         crd_sum = {1'b0, crd_q[p]} + (CRD_W+1)'(crd_rtn[p]) - (CRD_W+1)'(cap[p]);
         if (crd_sum > (CRD_W+1)'(CRD_MAX)) begin
            crd_nxt[p] = CRD_W'(CRD_MAX);
         end else begin
            crd_nxt[p] = crd_sum[CRD_W-1:0];
         end
      end
   end

   // Acknowledge the winning requester of any port that captures this cycle
   always_comb begin
      req_rdy = '0;
      for (int i = 0; i < R_REQ_NUM; i++) begin
         req_rdy[i] = ~rst & req_vld[i] & cap[req_sel[i]] & (win_idx[req_sel[i]] == IDX_W'(i));
      end
   end

   // Per-port grant register, round-robin pointer and credit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_vld <= '0;
         gnt_idx <= '0;
         rr_ptr  <= '0;
         for (int p = 0; p < 4; p++) begin
            crd_q[p] <= CRD_W'(CRD_MAX);
         end
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (cap[p]) begin
               gnt_vld[p] <= 1'b1;
               gnt_idx[p] <= win_idx[p];
               rr_ptr[p]  <= rr_nxt[p];
            end else if (gnt_vld[p] && gnt_rdy[p]) begin
               gnt_vld[p] <= 1'b0;
            end
            crd_q[p] <= crd_nxt[p];
         end
      end
   end

   // Flag a credit return into a full counter; the counter itself saturates
   always_ff @(posedge clk) begin
      for (int p = 0; p < 4; p++) begin
         if (!rst) begin
            assert (!(crd_rtn[p] && !cap[p] && (crd_q[p] == CRD_W'(CRD_MAX))))
               else $warning("credit overflow on port %0d", p);
         end
      end
   end

endmodule

// File: tb/tb_rd_xbar_port_scheduler.sv
// tb/tb_rd_xbar_port_scheduler.sv - directed self-checking bench for rd_xbar_port_scheduler
module tb_rd_xbar_port_scheduler;

   logic            clk;
   logic            rst;
   logic [7:0]      req_vld;
   logic [7:0][1:0] req_sel;
   logic [7:0]      req_rdy;
   logic [3:0]      port_en;
   logic [3:0]      gnt_vld;
   logic [3:0][2:0] gnt_idx;
   logic [3:0]      gnt_rdy;
   logic [3:0]      crd_rtn;
   logic [3:0][2:0] crd_cnt;

   int total;
   int bad;

   rd_xbar_port_scheduler #(.R_REQ_NUM(8), .CRD_MAX(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_vld (req_vld),
      .req_sel (req_sel),
      .req_rdy (req_rdy),
      .port_en (port_en),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .gnt_rdy (gnt_rdy),
      .crd_rtn (crd_rtn),
      .crd_cnt (crd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_vld = '0;
      crd_rtn = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [11:0] exp_idx;
      logic        odd;
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      req_vld = 8'hFF;
      req_sel = '0;
      port_en = 4'hF;
      gnt_rdy = 4'hF;
      crd_rtn = 4'h0;
      #2;
      chk("rst_gnt_vld", 32'(gnt_vld), 32'h0);
      chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
      chk("rst_crd", 32'(crd_cnt), {20'h0, 3'd4, 3'd4, 3'd4, 3'd4});
      chk("rst_req_rdy", 32'(req_rdy), 32'h0);
      tick();
      rst = 1'b0;
      req_vld = '0;

      // single request to port 2
      req_vld = 8'h01;
      req_sel[0] = 2'd2;
      settle();
      chk("t1_req_rdy", 32'(req_rdy), 32'h01);
      tick();
      req_vld = 8'h00;
      settle();
      chk("t1_gnt_vld", 32'(gnt_vld), 32'h4);
      chk("t1_gnt_idx2", 32'(gnt_idx[2]), 32'd0);
      chk("t1_crd2", 32'(crd_cnt[2]), 32'd3);
      tick();
      chk("t1_drain", 32'(gnt_vld), 32'h0);

      // requesters 1, 3, 6 to port 0 until credits run out
      req_sel = '0;
      req_vld = 8'h4A;
      settle();
      chk("t2_rdy_a", 32'(req_rdy), 32'h02);
      tick();
      chk("t2_idx_a", 32'(gnt_idx[0]), 32'd1);
      chk("t2_rdy_b", 32'(req_rdy), 32'h08);
      tick();
      chk("t2_idx_b", 32'(gnt_idx[0]), 32'd3);
      chk("t2_rdy_c", 32'(req_rdy), 32'h40);
      tick();
      chk("t2_idx_c", 32'(gnt_idx[0]), 32'd6);
      chk("t2_rdy_d", 32'(req_rdy), 32'h02);
      tick();
      chk("t2_idx_d", 32'(gnt_idx[0]), 32'd1);
      chk("t2_vld_d", 32'(gnt_vld), 32'h1);
      chk("t2_crd_empty", 32'(crd_cnt[0]), 32'd0);
      chk("t2_rdy_stall", 32'(req_rdy), 32'h00);
      tick();
      chk("t2_drained", 32'(gnt_vld), 32'h0);
      chk("t2_rdy_stall2", 32'(req_rdy), 32'h00);
      crd_rtn = 4'h1;
      tick();
      crd_rtn = 4'h0;
      settle();
      chk("t2_crd_back", 32'(crd_cnt[0]), 32'd1);
      chk("t2_rdy_ret", 32'(req_rdy), 32'h08);
      tick();
      chk("t2_idx_ret", 32'(gnt_idx[0]), 32'd3);
      chk("t2_vld_ret", 32'(gnt_vld), 32'h1);
      chk("t2_crd_ret", 32'(crd_cnt[0]), 32'd0);
      do_reset();

      // port 1 held by downstream backpressure
      req_sel[2] = 2'd1;
      req_sel[4] = 2'd1;
      req_vld = 8'h14;
      gnt_rdy = 4'b1101;
      settle();
      chk("t3_rdy_a", 32'(req_rdy), 32'h04);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t3_hold_vld", 32'(gnt_vld[1]), 32'd1);
         chk("t3_hold_idx", 32'(gnt_idx[1]), 32'd2);
         chk("t3_hold_rdy", 32'(req_rdy), 32'h00);
      end
      gnt_rdy = 4'hF;
      settle();
      chk("t3_rdy_b", 32'(req_rdy), 32'h10);
      tick();
      req_vld = 8'h00;
      settle();
      chk("t3_idx_b", 32'(gnt_idx[1]), 32'd4);
      chk("t3_vld_b", 32'(gnt_vld), 32'h2);
      chk("t3_crd_b", 32'(crd_cnt[1]), 32'd2);
      do_reset();

      // two requesters per port, full throughput with steady credit return
      for (int i = 0; i < 8; i++) begin
         req_sel[i] = 2'(i / 2);
      end
      req_vld = 8'hFF;
      settle();
      chk("t4_rdy_first", 32'(req_rdy), 32'h55);
      for (int c = 1; c <= 6; c++) begin
         tick();
         crd_rtn = 4'hF;
         settle();
         odd = (c % 2) == 1;
         exp_idx = odd ? {3'd6, 3'd4, 3'd2, 3'd0} : {3'd7, 3'd5, 3'd3, 3'd1};
         chk("t4_gnt_vld", 32'(gnt_vld), 32'hF);
         chk("t4_gnt_idx", 32'(gnt_idx), 32'(exp_idx));
         chk("t4_crd", 32'(crd_cnt), {20'h0, 3'd3, 3'd3, 3'd3, 3'd3});
         chk("t4_rdy", 32'(req_rdy), odd ? 32'hAA : 32'h55);
      end
      do_reset();

      // port enable gating and reset during a stall
      req_sel = '0;
      req_sel[7] = 2'd3;
      req_vld = 8'h80;
      port_en = 4'b0111;
      settle();
      chk("t5_dis_rdy", 32'(req_rdy), 32'h00);
      tick();
      chk("t5_dis_vld", 32'(gnt_vld), 32'h0);
      chk("t5_dis_crd", 32'(crd_cnt[3]), 32'd4);
      port_en = 4'hF;
      settle();
      chk("t5_en_rdy", 32'(req_rdy), 32'h80);
      gnt_rdy = 4'b0111;
      tick();
      chk("t5_en_vld", 32'(gnt_vld), 32'h8);
      chk("t5_en_idx", 32'(gnt_idx[3]), 32'd7);
      chk("t5_stall_rdy", 32'(req_rdy), 32'h00);
      rst = 1'b1;
      settle();
      chk("t5_rst_vld", 32'(gnt_vld), 32'h0);
      chk("t5_rst_crd", 32'(crd_cnt), {20'h0, 3'd4, 3'd4, 3'd4, 3'd4});
      chk("t5_rst_rdy", 32'(req_rdy), 32'h00);
      gnt_rdy = 4'hF;
      do_reset();

      // credit return into a full counter saturates
      crd_rtn = 4'h1;
      tick();
      crd_rtn = 4'h0;
      settle();
      chk("t6_sat", 32'(crd_cnt[0]), 32'd4);
      chk("t6_sat_vld", 32'(gnt_vld), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rd_xbar_port_scheduler.md
Name: rd_xbar_port_scheduler

Overview:
- Credit-based round-robin scheduler for the N-to-4 read request crossbar.
- Each of R_REQ_NUM requesters targets one of 4 output ports, selected by cmd_addr[63:62].
- Per port, the block grants one requester per cycle, registers the winner index, and presents it downstream with a valid/ready handshake.
- Per-port credits bound the number of outstanding requests at each cache bank; the crossbar payload mux is steered by gnt_idx.

Parameters:
- R_REQ_NUM, 8, number of read requesters.
- CRD_MAX, 4, reset/maximum credits per output port (legal range 1..15).
- IDX_W, $clog2(R_REQ_NUM), derived requester index width.
- CRD_W, $clog2(CRD_MAX+1), derived credit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_vld  in  R_REQ_NUM  requester valid.
- req_sel  in  2 x R_REQ_NUM  target port per requester (cmd_addr[63:62]).
- req_rdy  out  R_REQ_NUM  requester accepted this cycle.
- port_en  in  4  port enable; 0 blocks new grants to that port.
- gnt_vld  out  4  registered grant valid per port.
- gnt_idx  out  IDX_W x 4  winning requester index per port.
- gnt_rdy  in  4  downstream accepts grant.
- crd_rtn  in  4  one credit returned per asserted bit per cycle.
- crd_cnt  out  CRD_W x 4  current credits per port (debug/status).

Behaviour:
- Reset values: gnt_vld=0, gnt_idx=0, rr_ptr[p]=0, crd_cnt[p]=CRD_MAX. req_rdy is 0 while rst is asserted.
- Reset mid-operation drops any held grant with no handshake. Credits return to CRD_MAX.
- Per-port candidate set: cand[p][i] = req_vld[i] & (req_sel[i]==p).
- Capture condition: cap[p] = port_en[p] & (crd_cnt[p]!=0) & (|cand[p]) & (~gnt_vld[p] | gnt_rdy[p]).
  - Draining and refilling in the same cycle is allowed, giving 1 grant/cycle/port throughput.
- Round-robin arbitration:
  - Priority starts at rr_ptr[p] and wraps R_REQ_NUM-1 -> 0.
  - Winner w gets req_rdy[w]=1 combinationally in the same cycle. All other requesters get req_rdy=0.
  - A requester targets exactly one port, so at most one req_rdy per requester.
- On cap[p]:
  - gnt_vld[p]<=1 and gnt_idx[p]<=w.
  - rr_ptr[p]<=(w+1) mod R_REQ_NUM.
  - Credit consumed at capture.
- On gnt_vld[p]&gnt_rdy[p] with no cap, gnt_vld[p]<=0.
- While gnt_vld[p]=1 and gnt_rdy[p]=0, gnt_idx[p] is held stable.
- Latency: req handshake at cycle T -> gnt_vld at T+1.
- Credit update: crd_cnt[p] next = crd_cnt[p] - cap[p] + crd_rtn[p].
  - Simultaneous capture and return leaves the count unchanged.
- Empty credits (crd_cnt=0): no capture and req_rdy=0 for that port's requesters. An existing registered grant may still drain.
- Overflow: crd_rtn when crd_cnt==CRD_MAX and no cap is illegal. The counter saturates at CRD_MAX and a simulation assertion fires.
- port_en deassert:
  - Blocks new captures only.
  - A held grant still completes.
  - rr_ptr and credits are unaffected.
- Requester valid may drop without a handshake. The scheduler keeps no state per requester.
- The four ports are fully independent and may all capture in the same cycle.

Test Plan:
- Reset, then req_vld=8'h01, req_sel[0]=2 -> req_rdy=8'h01 in the same cycle; next cycle gnt_vld=4'b0100, gnt_idx[2]=0; crd_cnt[2]=3.
- Requesters 1, 3, 6 all to port 0 continuously, gnt_rdy=1, no crd_rtn -> grants 1, 3, 6, 1 on consecutive cycles; then stall with crd_cnt[0]=0 and req_rdy=0; a single crd_rtn[0] pulse -> grant 3 one cycle later.
- Port 1 granted with gnt_rdy[1]=0 for 5 cycles -> gnt_vld[1] and gnt_idx[1] stable; no new req_rdy to port-1 requesters; on gnt_rdy=1, next winner captured in the same cycle.
- All 8 requesters spread 2 per port, gnt_rdy=4'hF, crd_rtn=4'hF every cycle -> every port grants each cycle, alternating its two requesters; crd_cnt stays at CRD_MAX-1.
- port_en[3]=0 with requester 7 to port 3 -> no req_rdy[7], gnt_vld[3]=0; re-enable -> grant next cycle. Assert rst mid-stall -> gnt_vld=0 and crd_cnt=4 immediately.
- crd_rtn[0] with crd_cnt[0]=4 and no capture -> count stays 4; assertion flagged.
